// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
//  Module   : prog_loader
//  Purpose  : Byte-serial program loader. Receives a framed image
//             (SYNC, ADDR, LEN, DATA..., CSUM) over a four-phase strobe/ack
//             handshake and writes the payload into instruction memory,
//             holding the CPU in reset while loading or after a failure.
//  Revision : 1.0 - initial release
// ============================================================================
module prog_loader #(
    parameter int          ADDR_W      = 8,
    parameter int          SYNC_STAGES = 2,
    parameter logic [7:0]  SYNC_BYTE   = 8'hA5,
    parameter logic [15:0] TIMEOUT     = 16'd50000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [7:0]        data_in,
    input  logic              strobe_in,
    output logic              ack_out,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_rst_n,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_ADDR = 3'd1,
        S_LEN  = 3'd2,
        S_DATA = 3'd3,
        S_SUM  = 3'd4,
        S_DONE = 3'd5,
        S_ERR  = 3'd6
    } state_t;

    state_t                  state_q, state_d;
    logic [SYNC_STAGES-1:0]  sync_q;
    logic                    strobe_prev_q;
    logic [ADDR_W-1:0]       ptr_q, ptr_d;
    logic [8:0]              cnt_q, cnt_d;       // 9 bits so LEN=0 can mean 256
    logic [7:0]              sum_q, sum_d;
    logic [15:0]             idle_q, idle_d;
    logic                    we_q, we_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic [7:0]              wdata_q, wdata_d;
    logic                    cpu_rst_n_q, cpu_rst_n_d;
    logic                    done_q, done_d;
    logic                    err_q, err_d;

    logic                    w_evt;
    logic                    w_busy;
    logic [7:0]              w_sum_add;

    // One event per rising edge of the synchronized strobe, however long it is held.
    assign w_evt     = sync_q[SYNC_STAGES-1] & ~strobe_prev_q;
    assign w_busy    = (state_q == S_ADDR) || (state_q == S_LEN) ||
                       (state_q == S_DATA) || (state_q == S_SUM);
    assign w_sum_add = sum_q + data_in;

    assign ack_out   = sync_q[SYNC_STAGES-1];
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign busy      = w_busy;
    assign done      = done_q;
    assign err       = err_q;

    // Strobe synchronizer and edge-detect history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q        <= '0;
            strobe_prev_q <= 1'b0;
        end else begin
            sync_q        <= {sync_q[SYNC_STAGES-2:0], strobe_in};
            strobe_prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            cnt_q       <= '0;
            sum_q       <= '0;
            idle_q      <= '0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rst_n_q <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            cnt_q       <= cnt_d;
            sum_q       <= sum_d;
            idle_q      <= idle_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rst_n_q <= cpu_rst_n_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    // Frame parser: next state, write strobe, checksum, idle timeout.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        idle_d  = '0;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;

        if (w_busy) begin
            idle_d = w_evt ? 16'd0 : (idle_q + 16'd1);
        end

        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (w_evt && (data_in == SYNC_BYTE)) begin
                    state_d = S_ADDR;
                    sum_d   = 8'd0;
                end
            end
            S_ADDR: begin
                if (w_evt) begin
                    ptr_d   = ADDR_W'(data_in);
                    sum_d   = data_in;
                    state_d = S_LEN;
                end
            end
            S_LEN: begin
                if (w_evt) begin
                    cnt_d   = (data_in == 8'd0) ? 9'd256 : {1'b0, data_in};
                    sum_d   = w_sum_add;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (w_evt) begin
                    we_d    = 1'b1;
                    addr_d  = ptr_q;
                    wdata_d = data_in;
                    ptr_d   = ptr_q + 1'b1;
                    sum_d   = w_sum_add;
                    cnt_d   = cnt_q - 9'd1;
                    if (cnt_q == 9'd1) begin
                        state_d = S_SUM;
                    end
                end
            end
            S_SUM: begin
                if (w_evt) begin
                    state_d = (w_sum_add == 8'd0) ? S_DONE : S_ERR;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // A byte event always wins over an expiring idle counter.
        if ((TIMEOUT != 16'd0) && w_busy && !w_evt && (idle_d == TIMEOUT)) begin
            state_d = S_ERR;
        end
    end

    // Status outputs are registered images of the upcoming state.
    always_comb begin
        cpu_rst_n_d = (state_d == S_IDLE) || (state_d == S_DONE);
        done_d      = (state_d == S_DONE);
        err_d       = (state_d == S_ERR);
    end

endmodule
`default_nettype wire

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Byte-serial program loader: the writer end of the CPU core's instruction-memory read path.
- Receives a framed program image from an external host over the 8-bit dedicated inputs, using a four-phase strobe/ack handshake.
- Writes each payload byte into instruction memory through a single write port.
- Holds the CPU in reset while a load is in progress or after a failed load.

Parameters:
- ADDR_W, 8, instruction-memory address width. Image address wraps mod 2^ADDR_W.
- SYNC_STAGES, 2, synchronizer depth for strobe_in. Minimum 2.
- SYNC_BYTE, 8'hA5, frame start marker.
- TIMEOUT, 16'd50000, maximum idle cycles between byte events inside a frame. 0 disables the timeout.

Ports:
- clk, input, 1, system clock.
- rst_n, input, 1, asynchronous active-low reset.
- data_in, input, 8, host data byte. The host holds it stable while strobe_in is high.
- strobe_in, input, 1, host byte strobe. Asynchronous to clk.
- ack_out, output, 1, handshake acknowledge.
- mem_we, output, 1, instruction-memory write enable, one-cycle pulse.
- mem_addr, output, ADDR_W, write address.
- mem_wdata, output, 8, write data.
- cpu_rst_n, output, 1, active-low reset to the CPU core.
- busy, output, 1, frame in progress.
- done, output, 1, last frame loaded with a good checksum (sticky).
- err, output, 1, last frame failed on checksum or timeout (sticky).

Behaviour:
- Reset (async, rst_n low):
  - State = IDLE.
  - mem_we, ack_out, busy, done, err = 0.
  - cpu_rst_n = 0.
  - mem_addr and mem_wdata = 0.
  - Synchronizer flops and counters = 0.
- Handshake:
  - strobe_in passes through SYNC_STAGES flops; ack_out equals the last synchronizer stage.
  - Byte event = rising edge of the synchronized strobe. data_in is sampled on that cycle.
  - Host sequence: drive data, raise strobe, wait for ack high, drop strobe, wait for ack low.
  - Pin-to-event latency is SYNC_STAGES cycles. One event per strobe pulse.
- Frame format: SYNC_BYTE, ADDR, LEN, LEN data bytes, CSUM.
  - LEN = 0 means 256 bytes.
  - Running 8-bit sum S covers ADDR, LEN and all data bytes.
  - The frame passes when (S + CSUM) mod 256 == 0.
- FSM states: IDLE, ADDR, LEN, DATA, SUM, DONE, ERR.
- IDLE, DONE, ERR:
  - A byte event with value SYNC_BYTE moves to ADDR and clears done, err and S.
  - Any other byte is ignored; no write.
- ADDR: latch the start address into the write pointer; S = byte; go to LEN.
- LEN: latch the remaining count (0 maps to 256); S += byte; go to DATA.
- DATA, per byte event:
  - Next cycle: mem_we = 1 for exactly one cycle, mem_addr = pointer, mem_wdata = byte.
  - Then pointer += 1 (wraps mod 2^ADDR_W), S += byte, count -= 1.
  - When the count reaches 0, go to SUM.
  - SYNC_BYTE values inside DATA are ordinary data; there is no resync.
- SUM: on the byte event, go to DONE (done = 1) if the checksum passes, else ERR (err = 1).
- Timeout:
  - Only states ADDR, LEN, DATA and SUM time out.
  - An idle counter resets on each byte event and increments otherwise.
  - When it reaches TIMEOUT (nonzero), go to ERR with err = 1.
- Writes are committed as bytes arrive. An error does not roll back memory.
- busy = 1 in states ADDR, LEN, DATA and SUM.
- cpu_rst_n (registered) = 0 when busy or in ERR; 1 in IDLE (after reset release) and in DONE.
  - It goes low the cycle after the SYNC_BYTE event.
  - It goes high the cycle after a good CSUM event.
- done and err are mutually exclusive. Both stay held until the next SYNC_BYTE or a reset.
- Reset mid-frame:
  - Outputs return to reset values immediately. No partial mem_we pulse.
  - After release: state IDLE, cpu_rst_n = 1 one cycle later.
- Strobe held high indefinitely produces one byte event only.

Test Plan:
- Good frame: A5, 04, 03, 13, 34, 45, 6D.
  - Expect mem_we pulses: addr 04/data 13, 05/34, 06/45.
  - Expect done = 1, err = 0, cpu_rst_n low from after A5 until after 6D, then high.
- Bad checksum: same frame with CSUM 6E.
  - Expect the same three writes to occur.
  - Expect err = 1, done = 0, cpu_rst_n = 0 held.
  - Then send the good frame: err clears, done = 1.
- Address wrap: A5, FE, 03, 11, 22, 33, 99.
  - Expect writes FE/11, FF/22, 00/33 and done = 1.
- Garbage before sync: 00, FF, 5A, then the good frame.
  - Expect no mem_we and busy = 0 during the garbage bytes.
  - Expect the frame to load normally.
- Timeout with TIMEOUT = 100: send A5, 10, then go idle for 101 cycles.
  - Expect err = 1, busy = 0, state accepts a new A5.
  - Expect that a subsequent A5 clears err.
- Reset mid-DATA: assert rst_n low after 2 of 3 data bytes.
  - Expect mem_we, busy and cpu_rst_n to drop to 0 asynchronously.
  - After release: IDLE, cpu_rst_n = 1, and the remaining byte is ignored.
- Handshake: drop strobe_in only after ack_out rises.
  - Expect ack_out to rise exactly SYNC_STAGES cycles after strobe_in.
  - Expect exactly one write per pulse with strobe held high for 20 cycles.
